// File: rtl/rv32e_mem_arbiter_if.sv
// Requester and memory-side signals of the fetch/load-store RAM arbiter.
// The slave modport is the arbiter's view; master is the CPU + RAM environment.
interface rv32e_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_ack;
    logic [31:0]           i_rdata;
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [31:0]           d_wdata;
    logic                  d_ack;
    logic [31:0]           d_rdata;
    logic                  d_err;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, d_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, d_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/rv32e_mem_arbiter.sv
// Shares one single-port synchronous RAM between the fetch and load/store ports.
// One access in flight at a time; data wins unless it has starved the fetch side.
module rv32e_mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 2
) (
    input  logic                clk,
    input  logic                reset,
    rv32e_mem_arbiter_if.slave  bus,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    localparam logic [3:0]            SL    = 4'(STARVE_LIMIT);
    localparam logic [3:0]            LAT   = 4'(MEM_LATENCY);
    localparam logic [ADDR_WIDTH-1:0] AMASK = ~ADDR_WIDTH'(3);

    state_e                state_q;
    logic                  gnt_data_q, we_q;
    logic [3:0]            streak_q, lat_q;
    logic                  i_ack_q, d_ack_q, d_err_q, mem_en_q, mem_we_q, busy_q;
    logic [31:0]           i_rdata_q, d_rdata_q, mem_wdata_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  pick_data, pick_fetch, d_misal;

    always_comb begin
        pick_data  = bus.d_req && !(bus.i_req && (streak_q == SL));
        pick_fetch = bus.i_req && !pick_data;
        d_misal    = (bus.d_addr & ~AMASK) != '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_data_q  <= 1'b0;
            we_q        <= 1'b0;
            streak_q    <= '0;
            lat_q       <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            mem_wdata_q <= '0;
            mem_addr_q  <= '0;
        end else begin
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            d_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_data) begin
                        gnt_data_q  <= 1'b1;
                        we_q        <= bus.d_we;
                        mem_addr_q  <= bus.d_addr & AMASK;
                        mem_wdata_q <= bus.d_wdata;
                        busy_q      <= 1'b1;
                        if (!bus.i_req)        streak_q <= '0;
                        else if (streak_q != SL) streak_q <= streak_q + 4'd1;
                        // misaligned data never touches the RAM
                        if (d_misal) begin
                            state_q <= RESP;
                            d_ack_q <= 1'b1;
                            d_err_q <= 1'b1;
                        end else begin
                            state_q  <= ISSUE;
                            mem_en_q <= 1'b1;
                            mem_we_q <= bus.d_we;
                        end
                    end else if (pick_fetch) begin
                        gnt_data_q <= 1'b0;
                        we_q       <= 1'b0;
                        mem_addr_q <= bus.i_addr & AMASK;
                        streak_q   <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= ISSUE;
                        mem_en_q   <= 1'b1;
                        mem_we_q   <= 1'b0;
                    end
                end
                ISSUE: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    if (we_q) begin
                        state_q <= RESP;
                        d_ack_q <= gnt_data_q;
                        i_ack_q <= !gnt_data_q;
                    end else begin
                        state_q <= WAIT;
                        lat_q   <= LAT;
                    end
                end
                WAIT: begin
                    lat_q <= lat_q - 4'd1;
                    if (lat_q == 4'd1) begin
                        state_q <= RESP;
                        d_ack_q <= gnt_data_q;
                        i_ack_q <= !gnt_data_q;
                        if (gnt_data_q) d_rdata_q <= bus.mem_rdata;
                        else            i_rdata_q <= bus.mem_rdata;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.i_ack     = i_ack_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_err     = d_err_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_rv32e_mem_arbiter.sv
// Directed bench: dut1 with a 1-cycle RAM model, dut2 (MEM_LATENCY=3) with a
// cycle-stamped read-data pattern so the capture cycle is observable.
module tb_rv32e_mem_arbiter;
    logic clk = 1'b0;
    logic rst1, rst2, mem_init;
    logic busy1, busy2;
    logic [31:0] mem [0:255];
    logic [31:0] rd1;
    logic [15:0] cyc = 16'd0;
    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    rv32e_mem_arbiter_if #(.ADDR_WIDTH(32)) b1();
    rv32e_mem_arbiter_if #(.ADDR_WIDTH(32)) b2();

    rv32e_mem_arbiter #(.ADDR_WIDTH(32), .MEM_LATENCY(1), .STARVE_LIMIT(2)) dut1 (
        .clk(clk), .reset(rst1), .bus(b1), .busy(busy1));
    rv32e_mem_arbiter #(.ADDR_WIDTH(32), .MEM_LATENCY(3), .STARVE_LIMIT(2)) dut2 (
        .clk(clk), .reset(rst2), .bus(b2), .busy(busy2));

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[4]  <= 32'h0050_0093;
            mem[32] <= 32'h1111_1111;
            rd1     <= 32'h0;
        end else if (b1.mem_en) begin
            if (b1.mem_we) mem[b1.mem_addr[9:2]] <= b1.mem_wdata;
            else           rd1 <= mem[b1.mem_addr[9:2]];
        end
    end
    assign b1.mem_rdata = rd1;

    always @(posedge clk) cyc <= cyc + 16'd1;
    assign b2.mem_rdata = {16'hC0DE, cyc};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Starts in the IDLE cycle; lat counts that cycle through the ack cycle.
    task automatic run1(input bit dat, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output int en_n, output int we_n,
                        output logic [31:0] ma, output logic err, output logic ackd);
        en_n = 0; we_n = 0; lat = 1; ma = 32'h0; err = 1'b0; ackd = 1'b0;
        @(negedge clk);
        if (dat) begin
            b1.d_req = 1'b1; b1.d_we = we; b1.d_addr = addr; b1.d_wdata = wd;
        end else begin
            b1.i_req = 1'b1; b1.i_addr = addr;
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            lat++;
            if (b1.mem_en) begin en_n++; ma = b1.mem_addr; end
            if (b1.mem_we) we_n++;
            if (b1.i_ack || b1.d_ack) begin
                err = b1.d_err; ackd = b1.d_ack;
                break;
            end
        end
        b1.i_req = 1'b0; b1.d_req = 1'b0;
    endtask

    task automatic fetch2(input logic [31:0] addr, output int lat, output logic [15:0] e);
        bit seen;
        lat = 1; e = 16'h0; seen = 1'b0;
        @(negedge clk);
        b2.i_req = 1'b1; b2.i_addr = addr;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            lat++;
            if (b2.mem_en && !seen) begin e = cyc; seen = 1'b1; end
            if (b2.i_ack) break;
        end
        b2.i_req = 1'b0;
    endtask

    initial begin
        int lat, en_n, we_n, n, coin, acks;
        logic [31:0] ma;
        logic err, ackd;
        logic [5:0] order;
        logic [15:0] e;

        rst1 = 1'b1; rst2 = 1'b1; mem_init = 1'b1;
        b1.i_req = 1'b0; b1.i_addr = '0; b1.d_req = 1'b0; b1.d_we = 1'b0; b1.d_addr = '0; b1.d_wdata = '0;
        b2.i_req = 1'b0; b2.i_addr = '0; b2.d_req = 1'b0; b2.d_we = 1'b0; b2.d_addr = '0; b2.d_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",   32'(busy1), 32'h0);
        chk("rst_acks",   32'({b1.i_ack, b1.d_ack, b1.d_err}), 32'h0);
        chk("rst_mem_en", 32'({b1.mem_en, b1.mem_we}), 32'h0);
        chk("rst_i_rd",   b1.i_rdata, 32'h0);
        chk("rst_d_rd",   b1.d_rdata, 32'h0);
        chk("rst_maddr",  b1.mem_addr, 32'h0);
        chk("rst_mwdata", b1.mem_wdata, 32'h0);
        rst1 = 1'b0; rst2 = 1'b0; mem_init = 1'b0;

        // fetch, MEM_LATENCY=1
        run1(1'b0, 1'b0, 32'h10, 32'h0, lat, en_n, we_n, ma, err, ackd);
        chk("f_lat",   32'(lat), 32'd4);
        chk("f_data",  b1.i_rdata, 32'h0050_0093);
        chk("f_en_n",  32'(en_n), 32'd1);
        chk("f_we_n",  32'(we_n), 32'd0);
        chk("f_maddr", ma, 32'h10);
        chk("f_port",  32'(ackd), 32'd0);

        run1(1'b0, 1'b0, 32'h13, 32'h0, lat, en_n, we_n, ma, err, ackd);
        chk("f13_maddr", ma, 32'h10);
        chk("f13_data",  b1.i_rdata, 32'h0050_0093);

        // store then load
        run1(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, lat, en_n, we_n, ma, err, ackd);
        chk("st_lat",  32'(lat), 32'd3);
        chk("st_we_n", 32'(we_n), 32'd1);
        chk("st_en_n", 32'(en_n), 32'd1);
        chk("st_port", 32'(ackd), 32'd1);
        chk("st_err",  32'(err), 32'd0);
        chk("st_ram",  mem[16], 32'hDEAD_BEEF);

        run1(1'b1, 1'b0, 32'h40, 32'h0, lat, en_n, we_n, ma, err, ackd);
        chk("ld_lat",  32'(lat), 32'd4);
        chk("ld_data", b1.d_rdata, 32'hDEAD_BEEF);
        chk("ld_err",  32'(err), 32'd0);

        // misaligned
        run1(1'b1, 1'b0, 32'h42, 32'h0, lat, en_n, we_n, ma, err, ackd);
        chk("mis_lat",  32'(lat), 32'd2);
        chk("mis_en_n", 32'(en_n), 32'd0);
        chk("mis_err",  32'(err), 32'd1);
        chk("mis_port", 32'(ackd), 32'd1);
        chk("mis_data", b1.d_rdata, 32'hDEAD_BEEF);

        // contention: expect D D I D D I (1 = fetch)
        @(negedge clk);
        b1.i_req = 1'b1; b1.i_addr = 32'h10;
        b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'h40;
        n = 0; coin = 0; order = 6'h0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (b1.i_ack && b1.d_ack) coin++;
            if (b1.i_ack) begin order = {order[4:0], 1'b1}; n++; end
            else if (b1.d_ack) begin order = {order[4:0], 1'b0}; n++; end
            if (n == 6) break;
        end
        b1.i_req = 1'b0; b1.d_req = 1'b0;
        chk("ct_acks",  32'(n), 32'd6);
        chk("ct_order", 32'(order), 32'h09);
        chk("ct_coin",  32'(coin), 32'd0);

        // reset during a store's ISSUE cycle
        @(negedge clk); @(negedge clk);
        b1.d_req = 1'b1; b1.d_we = 1'b1; b1.d_addr = 32'h80; b1.d_wdata = 32'h55AA_55AA;
        @(negedge clk);
        chk("rs_pre_en", 32'({b1.mem_en, b1.mem_we}), 32'h3);
        rst1 = 1'b1;
        #1;
        chk("rs_en",   32'({b1.mem_en, b1.mem_we}), 32'h0);
        chk("rs_busy", 32'(busy1), 32'h0);
        chk("rs_drd",  b1.d_rdata, 32'h0);
        b1.d_req = 1'b0;
        repeat (2) @(negedge clk);
        rst1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rs_ram", mem[32], 32'h1111_1111);

        // MEM_LATENCY=3 fetch
        fetch2(32'h20, lat, e);
        chk("l3_lat",  32'(lat), 32'd6);
        chk("l3_data", b2.i_rdata, {16'hC0DE, 16'(e + 16'd3)});

        // reset during WAIT
        @(negedge clk); @(negedge clk);
        b2.i_req = 1'b1; b2.i_addr = 32'h24;
        repeat (3) @(negedge clk);
        chk("rw_pre_busy", 32'(busy2), 32'h1);
        rst2 = 1'b1;
        #1;
        chk("rw_busy", 32'(busy2), 32'h0);
        chk("rw_en",   32'(b2.mem_en), 32'h0);
        chk("rw_acks", 32'({b2.i_ack, b2.d_ack}), 32'h0);
        chk("rw_ird",  b2.i_rdata, 32'h0);
        b2.i_req = 1'b0;
        repeat (2) @(negedge clk);
        rst2 = 1'b0;
        acks = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (b2.i_ack || b2.d_ack) acks++;
        end
        chk("rw_noack", 32'(acks), 32'd0);
        fetch2(32'h28, lat, e);
        chk("rw_lat",  32'(lat), 32'd6);
        chk("rw_data", b2.i_rdata, {16'hC0DE, 16'(e + 16'd3)});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
